// File: rtl/comparator_nbit_pipe_if.sv
// comparator_nbit_pipe_if: operand/result bus for comparator_nbit_pipe.
// Carries the operand pair with its valid/ready handshake and the one-hot
// GT/EQ/LT result with its own valid/ready handshake.
// Optional feature macro: CMP_SIGNED_EN adds the per-transfer signed_mode bit.
interface comparator_nbit_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef CMP_SIGNED_EN
    logic             signed_mode;
`endif
    logic             in_valid;
    logic             in_ready;
    logic             GT;
    logic             EQ;
    logic             LT;
    logic             out_valid;
    logic             out_ready;

`ifdef CMP_SIGNED_EN
    modport master (
        output A, B, signed_mode, in_valid, out_ready,
        input  in_ready, GT, EQ, LT, out_valid
    );

    modport slave (
        input  A, B, signed_mode, in_valid, out_ready,
        output in_ready, GT, EQ, LT, out_valid
    );
`else
    modport master (
        output A, B, in_valid, out_ready,
        input  in_ready, GT, EQ, LT, out_valid
    );

    modport slave (
        input  A, B, in_valid, out_ready,
        output in_ready, GT, EQ, LT, out_valid
    );
`endif
endinterface

// File: rtl/comparator_nbit_pipe.sv
// comparator_nbit_pipe: pipelined WIDTH-bit magnitude comparator.
// Operands are resolved MSB-first, CHUNK bits per stage, so each stage only
// needs one CHUNK-bit compare plus a merge with the verdict from upstream.
// Slot 0 holds the registered operands; slot k feeds the compare of chunk k;
// the output register holds the final one-hot result, giving a latency of
// STAGES edges from acceptance to out_valid.
// The whole pipeline freezes while a result waits on out_ready.
// Optional feature macro: CMP_SIGNED_EN enables two's-complement compares
// selected per transfer by signed_mode.
module comparator_nbit_pipe #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic                  clk,
    input logic                  rst,
    comparator_nbit_pipe_if.slave bus
);
    localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = STAGES * CHUNK;

    logic          stall;
    logic [PW-1:0] a_in;
    logic [PW-1:0] b_in;

    logic [PW-1:0] a_q   [STAGES];
    logic [PW-1:0] b_q   [STAGES];
    logic          vld_q [STAGES];
    logic          und_q [STAGES];
    logic          gt_q  [STAGES];

    logic          nxt_und [STAGES];
    logic          nxt_gt  [STAGES];

    logic          out_valid_q;
    logic          gt_r;
    logic          eq_r;
    logic          lt_r;

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.GT       = gt_r;
    assign bus.EQ       = eq_r;
    assign bus.LT       = lt_r;

    // Condition operands: optional MSB flip to offset-binary, then zero-extend to whole chunks
    always_comb begin
        a_in = PW'(bus.A);
        b_in = PW'(bus.B);
`ifdef CMP_SIGNED_EN
        if (bus.signed_mode) begin
            a_in[WIDTH-1] = ~bus.A[WIDTH-1];
            b_in[WIDTH-1] = ~bus.B[WIDTH-1];
        end
`endif
    end

    // Per-stage chunk compare merged with the verdict carried from earlier stages
    for (genvar k = 0; k < STAGES; k++) begin : g_cmp
        localparam int HI = PW - 1 - k * CHUNK;
        logic [CHUNK-1:0] ca;
        logic [CHUNK-1:0] cb;
        assign ca         = a_q[k][HI -: CHUNK];
        assign cb         = b_q[k][HI -: CHUNK];
        assign nxt_und[k] = und_q[k] && (ca == cb);
        assign nxt_gt[k]  = und_q[k] ? (ca > cb) : gt_q[k];
    end

    // Advance every slot (bubbles included) unless the output is stalled; reset clears all valids
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                und_q[k] <= 1'b1;
                gt_q[k]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            gt_r        <= 1'b0;
            eq_r        <= 1'b0;
            lt_r        <= 1'b0;
        end else if (!stall) begin
            vld_q[0] <= bus.in_valid;
            a_q[0]   <= a_in;
            b_q[0]   <= b_in;
            und_q[0] <= 1'b1;
            gt_q[0]  <= 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                und_q[k] <= nxt_und[k-1];
                gt_q[k]  <= nxt_gt[k-1];
            end
            out_valid_q <= vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                gt_r <= !nxt_und[STAGES-1] && nxt_gt[STAGES-1];
                eq_r <= nxt_und[STAGES-1];
                lt_r <= !nxt_und[STAGES-1] && !nxt_gt[STAGES-1];
            end
        end
    end
endmodule

// File: tb/tb_comparator_nbit_pipe.sv
// tb_comparator_nbit_pipe: drives two comparator instances (8-bit/2-bit
// chunks and 7-bit/3-bit chunks) with the same operand stream and checks
// each against an arithmetic reference kept in per-instance queues.
// Optional feature macro: CMP_SIGNED_EN enables signed_mode stimulus.
module tb_comparator_nbit_pipe;
    localparam int W8 = 8;
    localparam int C8 = 2;
    localparam int S8 = 4;
    localparam int W7 = 7;
    localparam int C7 = 3;
    localparam int S7 = 3;
`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] res;
        int         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   lat_strict = 1'b1;
    exp_t q8[$];
    exp_t q7[$];
    bit   prev_stall8 = 1'b0;
    bit   prev_stall7 = 1'b0;
    logic [2:0] prev_res8 = '0;
    logic [2:0] prev_res7 = '0;

    always #5 clk = ~clk;

    comparator_nbit_pipe_if #(.WIDTH(W8)) bus8 ();
    comparator_nbit_pipe_if #(.WIDTH(W7)) bus7 ();

    comparator_nbit_pipe #(.WIDTH(W8), .CHUNK(C8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    comparator_nbit_pipe #(.WIDTH(W7), .CHUNK(C7)) dut7 (
        .clk (clk),
        .rst (rst),
        .bus (bus7)
    );

    // Reference: order of the two operands taken as w-bit numbers, signed if requested
    function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b,
                                           input int w, input logic sm);
        longint m, va, vb;
        m  = longint'(1) << w;
        va = longint'(a) & (m - 1);
        vb = longint'(b) & (m - 1);
        if (sm) begin
            if (va >= m / 2) va = va - m;
            if (vb >= m / 2) vb = vb - m;
        end
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, observe mid-cycle, then cross the rising edge
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic ordy);
        exp_t e;
        logic sm_eff;
        sm_eff = sm && SIGNED_EN;
        bus8.in_valid  = v;
        bus8.A         = a;
        bus8.B         = b;
        bus8.out_ready = ordy;
        bus7.in_valid  = v;
        bus7.A         = a[6:0];
        bus7.B         = b[6:0];
        bus7.out_ready = ordy;
`ifdef CMP_SIGNED_EN
        bus8.signed_mode = sm;
        bus7.signed_mode = sm;
`endif
        #1;
        if (rst) begin
            q8.delete();
            q7.delete();
            prev_stall8 = 1'b0;
            prev_stall7 = 1'b0;
        end else begin
            if (prev_stall8)
                check("dut8_stall_hold", {bus8.out_valid, bus8.GT, bus8.EQ, bus8.LT}, {1'b1, prev_res8});
            if (prev_stall7)
                check("dut7_stall_hold", {bus7.out_valid, bus7.GT, bus7.EQ, bus7.LT}, {1'b1, prev_res7});
            check("dut8_in_ready", bus8.in_ready, !(bus8.out_valid && !ordy));
            check("dut7_in_ready", bus7.in_ready, !(bus7.out_valid && !ordy));
            if (bus8.out_valid) check("dut8_onehot", $countones({bus8.GT, bus8.EQ, bus8.LT}), 1);
            if (bus7.out_valid) check("dut7_onehot", $countones({bus7.GT, bus7.EQ, bus7.LT}), 1);
            if (bus8.out_valid && ordy) begin
                check("dut8_pending", q8.size() != 0, 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("dut8_result", {bus8.GT, bus8.EQ, bus8.LT}, e.res);
                    if (lat_strict) check("dut8_latency", cycle - e.t, S8);
                end
            end
            if (bus7.out_valid && ordy) begin
                check("dut7_pending", q7.size() != 0, 1);
                if (q7.size() != 0) begin
                    e = q7.pop_front();
                    check("dut7_result", {bus7.GT, bus7.EQ, bus7.LT}, e.res);
                    if (lat_strict) check("dut7_latency", cycle - e.t, S7);
                end
            end
            prev_stall8 = bus8.out_valid && !ordy;
            prev_stall7 = bus7.out_valid && !ordy;
            prev_res8   = {bus8.GT, bus8.EQ, bus8.LT};
            prev_res7   = {bus7.GT, bus7.EQ, bus7.LT};
            if (v && bus8.in_ready) q8.push_back('{ref_cmp(a, b, W8, sm_eff), cycle + 1});
            if (v && bus7.in_ready) q7.push_back('{ref_cmp(a, b, W7, sm_eff), cycle + 1});
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    // Idle with out_ready high until both scoreboards empty, bounded
    task automatic drain();
        for (int i = 0; i < 50 && (q8.size() != 0 || q7.size() != 0); i++)
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("dut8_drain", q8.size(), 0);
        check("dut7_drain", q7.size(), 0);
    endtask

    // Directed sequence: reset, corner pairs, random stream, backpressure, mid-flight reset
    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.out_ready = 1'b1;
        bus7.in_valid = 1'b0; bus7.A = '0; bus7.B = '0; bus7.out_ready = 1'b1;
`ifdef CMP_SIGNED_EN
        bus8.signed_mode = 1'b0;
        bus7.signed_mode = 1'b0;
`endif
        rst = 1'b1;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("dut8_rst_out_valid", bus8.out_valid, 0);
        check("dut8_rst_gt", bus8.GT, 0);
        check("dut8_rst_eq", bus8.EQ, 0);
        check("dut8_rst_lt", bus8.LT, 0);
        check("dut8_rst_in_ready", bus8.in_ready, 1);
        check("dut7_rst_out_valid", bus7.out_valid, 0);
        check("dut7_rst_gt", bus7.GT, 0);
        check("dut7_rst_eq", bus7.EQ, 0);
        check("dut7_rst_lt", bus7.LT, 0);
        check("dut7_rst_in_ready", bus7.in_ready, 1);

        $display("[TB] single compare and corner pairs");
        step(1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1);
        drain();
        step(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
        step(1'b1, 8'h80, 8'h7F, 1'b1, 1'b1);
        step(1'b1, 8'h40, 8'h3F, 1'b0, 1'b1);
        step(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1);
        drain();

        $display("[TB] back-to-back random stream");
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rs = 1'($urandom);
            step(1'b1, ra, rb, rs, 1'b1);
        end
        drain();

        $display("[TB] backpressure mid-stream");
        lat_strict = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rs = 1'($urandom);
            step(1'b1, ra, rb, rs, !(i >= 8 && i < 13));
        end
        drain();
        lat_strict = 1'b1;

        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("dut8_no_stale", bus8.out_valid, 0);
            check("dut7_no_stale", bus7.out_valid, 0);
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        end
        step(1'b1, 8'h33, 8'h2C, 1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
